// File: rtl/param_leaf_router.sv
// Leaf router: one GPU port and NUM_SPINES spine uplinks, each behind an ingress FIFO.
// Local flits are round-robin arbitrated to the GPU; non-local GPU flits go up to free spines.
module param_leaf_router #(
    parameter int unsigned  DWIDTH     = 16,
    parameter int unsigned  FIFO_DEPTH = 8,
    parameter int unsigned  NUM_SPINES = 4,
    parameter logic [3:0]   GROUP_ID   = 4'b1000,
    localparam int unsigned GW         = $clog2(NUM_SPINES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arb_enable,
    input  logic [DWIDTH-1:0]          gpu_in_data,
    input  logic [5:0]                 gpu_in_dest,
    input  logic                       gpu_in_valid,
    output logic                       gpu_in_ready,
    output logic [DWIDTH-1:0]          gpu_out_data,
    output logic                       gpu_out_valid,
    input  logic                       gpu_out_ready,
    input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
    input  logic [NUM_SPINES*6-1:0]    spine_in_dest,
    input  logic [NUM_SPINES-1:0]      spine_in_valid,
    output logic [NUM_SPINES-1:0]      spine_in_ready,
    output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
    output logic [NUM_SPINES*6-1:0]    spine_out_dest,
    output logic [NUM_SPINES-1:0]      spine_out_valid,
    input  logic [NUM_SPINES-1:0]      spine_out_ready,
    output logic [NUM_SPINES:0]        fifo_full,
    output logic [NUM_SPINES:0]        fifo_empty,
    output logic [7:0]                 drop_count,
    output logic [GW-1:0]              current_grant,
    output logic [1:0]                 routing_direction,
    output logic                       busy
);

    localparam int unsigned NP  = NUM_SPINES + 1;
    localparam int unsigned GPU = NUM_SPINES;
    localparam int unsigned EW  = DWIDTH + 6;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned SW  = (NUM_SPINES > 1) ? $clog2(NUM_SPINES) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [NP-1:0]  in_valid;
    logic [EW-1:0]  in_ent [NP];
    logic [EW-1:0]  head [NP];
    logic [NP-1:0]  full, empty, push, pop, head_local;

    logic                  gpu_free;
    logic [NUM_SPINES-1:0] spine_free;
    logic                  down_fire, up_fire;
    logic [GW-1:0]         down_win, rr_down;
    logic [SW-1:0]         up_sel, rr_up;
    logic [NUM_SPINES-1:0] drop_vec;
    logic [8:0]            drop_sum, drop_total;
    logic [7:0]            drop_next;
    logic                  xfer_q;
    int unsigned           dn_idx, up_idx;

    always_comb begin
        for (int s = 0; s < NUM_SPINES; s++) begin
            in_valid[s] = spine_in_valid[s];
            in_ent[s]   = {spine_in_dest[s*6 +: 6], spine_in_data[s*DWIDTH +: DWIDTH]};
        end
        in_valid[GPU] = gpu_in_valid;
        in_ent[GPU]   = {gpu_in_dest, gpu_in_data};
    end

    for (genvar p = 0; p < NP; p++) begin : g_fifo
        logic [EW-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0] wr_ptr, rd_ptr;
        logic [AW:0]   count;

        // Ready is a function of registered occupancy only.
        assign full[p]       = (count == FULL_CNT);
        assign empty[p]      = (count == '0);
        assign push[p]       = in_valid[p] & ~full[p];
        assign head[p]       = mem[rd_ptr];
        assign head_local[p] = (head[p][EW-1 -: 4] == GROUP_ID);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[p]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[p])  rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(push[p]) - (AW+1)'(pop[p]);
            end
        end

        always_ff @(posedge clk) begin
            if (push[p]) mem[wr_ptr] <= in_ent[p];
        end
    end

    assign fifo_full      = full;
    assign fifo_empty     = empty;
    assign gpu_in_ready   = ~full[GPU];
    assign spine_in_ready = ~full[NUM_SPINES-1:0];

    assign gpu_free   = ~gpu_out_valid | gpu_out_ready;
    assign spine_free = ~spine_out_valid | spine_out_ready;

    always_comb begin
        down_fire = 1'b0;
        down_win  = '0;
        up_fire   = 1'b0;
        up_sel    = '0;
        drop_vec  = '0;
        pop       = '0;
        dn_idx    = 0;
        up_idx    = 0;
        if (arb_enable) begin
            for (int i = 0; i < NP; i++) begin
                dn_idx = (int'(rr_down) + i) % NP;
                if (!down_fire && gpu_free && !empty[dn_idx] && head_local[dn_idx]) begin
                    down_fire = 1'b1;
                    down_win  = GW'(dn_idx);
                end
            end
            // Head-of-line blocking on the GPU FIFO is intentional when no spine is free.
            if (!empty[GPU] && !head_local[GPU]) begin
                for (int i = 0; i < NUM_SPINES; i++) begin
                    up_idx = (int'(rr_up) + i) % NUM_SPINES;
                    if (!up_fire && spine_free[up_idx]) begin
                        up_fire = 1'b1;
                        up_sel  = SW'(up_idx);
                    end
                end
            end
            for (int s = 0; s < NUM_SPINES; s++) begin
                drop_vec[s] = !empty[s] && !head_local[s];
                pop[s]      = drop_vec[s] | (down_fire && (down_win == GW'(s)));
            end
            pop[GPU] = up_fire | (down_fire && (down_win == GW'(GPU)));
        end
    end

    always_comb begin
        drop_sum = '0;
        for (int s = 0; s < NUM_SPINES; s++) begin
            drop_sum = drop_sum + 9'(drop_vec[s]);
        end
        drop_total = {1'b0, drop_count} + drop_sum;
        drop_next  = drop_total[8] ? 8'hFF : drop_total[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpu_out_valid     <= 1'b0;
            gpu_out_data      <= '0;
            spine_out_valid   <= '0;
            spine_out_data    <= '0;
            spine_out_dest    <= '0;
            rr_down           <= '0;
            rr_up             <= '0;
            current_grant     <= '0;
            drop_count        <= '0;
            routing_direction <= 2'b00;
            xfer_q            <= 1'b0;
        end else begin
            if (down_fire) begin
                gpu_out_valid <= 1'b1;
                gpu_out_data  <= head[down_win][DWIDTH-1:0];
                current_grant <= down_win;
                rr_down       <= (down_win == GW'(GPU)) ? '0 : down_win + 1'b1;
            end else if (gpu_out_ready) begin
                gpu_out_valid <= 1'b0;
            end
            for (int s = 0; s < NUM_SPINES; s++) begin
                if (up_fire && (up_sel == SW'(s))) begin
                    spine_out_valid[s]               <= 1'b1;
                    spine_out_data[s*DWIDTH +: DWIDTH] <= head[GPU][DWIDTH-1:0];
                    spine_out_dest[s*6 +: 6]         <= head[GPU][EW-1 -: 6];
                end else if (spine_out_ready[s]) begin
                    spine_out_valid[s] <= 1'b0;
                end
            end
            if (up_fire) begin
                rr_up <= (up_sel == SW'(NUM_SPINES - 1)) ? '0 : up_sel + 1'b1;
            end
            drop_count        <= drop_next;
            routing_direction <= {up_fire, down_fire};
            xfer_q            <= up_fire | down_fire;
        end
    end

    assign busy = xfer_q | gpu_out_valid | (|spine_out_valid);

endmodule

// File: tb/tb_param_leaf_router.sv
// Self-checking bench for param_leaf_router: directed table, corner-case sequences,
// and a randomized run against a queue-based reference model.
module tb_param_leaf_router;

    localparam logic [3:0] GROUP = 4'b1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        arb_enable;
    logic [15:0] gpu_in_data;
    logic [5:0]  gpu_in_dest;
    logic        gpu_in_valid, gpu_in_ready;
    logic [15:0] gpu_out_data;
    logic        gpu_out_valid, gpu_out_ready;
    logic [63:0] spine_in_data;
    logic [23:0] spine_in_dest;
    logic [3:0]  spine_in_valid, spine_in_ready;
    logic [63:0] spine_out_data;
    logic [23:0] spine_out_dest;
    logic [3:0]  spine_out_valid, spine_out_ready;
    logic [4:0]  fifo_full, fifo_empty;
    logic [7:0]  drop_count;
    logic [2:0]  current_grant;
    logic [1:0]  routing_direction;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    param_leaf_router dut (
        .clk              (clk),
        .reset            (reset),
        .arb_enable       (arb_enable),
        .gpu_in_data      (gpu_in_data),
        .gpu_in_dest      (gpu_in_dest),
        .gpu_in_valid     (gpu_in_valid),
        .gpu_in_ready     (gpu_in_ready),
        .gpu_out_data     (gpu_out_data),
        .gpu_out_valid    (gpu_out_valid),
        .gpu_out_ready    (gpu_out_ready),
        .spine_in_data    (spine_in_data),
        .spine_in_dest    (spine_in_dest),
        .spine_in_valid   (spine_in_valid),
        .spine_in_ready   (spine_in_ready),
        .spine_out_data   (spine_out_data),
        .spine_out_dest   (spine_out_dest),
        .spine_out_valid  (spine_out_valid),
        .spine_out_ready  (spine_out_ready),
        .fifo_full        (fifo_full),
        .fifo_empty       (fifo_empty),
        .drop_count       (drop_count),
        .current_grant    (current_grant),
        .routing_direction(routing_direction),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arb_enable      = 1'b1;
        gpu_in_data     = '0;
        gpu_in_dest     = '0;
        gpu_in_valid    = 1'b0;
        gpu_out_ready   = 1'b1;
        spine_in_data   = '0;
        spine_in_dest   = '0;
        spine_in_valid  = '0;
        spine_out_ready = 4'hF;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic set_spine(input int s, input logic v, input logic [5:0] d,
                             input logic [15:0] x);
        spine_in_valid[s]       = v;
        spine_in_dest[s*6 +: 6] = d;
        spine_in_data[s*16 +: 16] = x;
    endtask

    task automatic push_one(input int port, input logic [5:0] d, input logic [15:0] x);
        if (port == 4) begin
            gpu_in_valid = 1'b1;
            gpu_in_dest  = d;
            gpu_in_data  = x;
        end else begin
            set_spine(port, 1'b1, d, x);
        end
        tick();
        gpu_in_valid   = 1'b0;
        spine_in_valid = '0;
    endtask

    // ---------------- reference model ----------------
    typedef logic [21:0] ent_t;
    ent_t        mq [5][$];
    logic        m_gv;
    logic [15:0] m_gd;
    logic [3:0]  m_sv;
    logic [15:0] m_sd [4];
    logic [5:0]  m_sdst [4];
    int          m_rr_down, m_rr_up, m_drops, m_grant;
    logic [1:0]  m_dir;
    logic        m_xfer;

    task automatic model_reset();
        for (int p = 0; p < 5; p++) mq[p].delete();
        m_gv = 1'b0; m_gd = '0; m_sv = '0;
        for (int s = 0; s < 4; s++) begin m_sd[s] = '0; m_sdst[s] = '0; end
        m_rr_down = 0; m_rr_up = 0; m_drops = 0; m_grant = 0; m_dir = 2'b00; m_xfer = 1'b0;
    endtask

    function automatic ent_t entry_of(input int p);
        if (p == 4) return {gpu_in_dest, gpu_in_data};
        return {spine_in_dest[p*6 +: 6], spine_in_data[p*16 +: 16]};
    endfunction

    function automatic logic valid_of(input int p);
        return (p == 4) ? gpu_in_valid : spine_in_valid[p];
    endfunction

    task automatic model_step();
        bit   hv [5];
        bit   hl [5];
        ent_t hd [5];
        bit   acc [5];
        int   win, usel, nd;
        for (int p = 0; p < 5; p++) begin
            hv[p]  = mq[p].size() > 0;
            hd[p]  = hv[p] ? mq[p][0] : '0;
            hl[p]  = (hd[p][21:18] == GROUP);
            acc[p] = valid_of(p) && (mq[p].size() < 8);
        end
        win = -1; usel = -1; nd = 0;
        if (arb_enable) begin
            if (!m_gv || gpu_out_ready) begin
                for (int i = 0; i < 5 && win < 0; i++) begin
                    int p = (m_rr_down + i) % 5;
                    if (hv[p] && hl[p]) win = p;
                end
            end
            if (hv[4] && !hl[4]) begin
                for (int i = 0; i < 4 && usel < 0; i++) begin
                    int s = (m_rr_up + i) % 4;
                    if (!m_sv[s] || spine_out_ready[s]) usel = s;
                end
            end
            for (int s = 0; s < 4; s++) begin
                if (hv[s] && !hl[s]) begin
                    void'(mq[s].pop_front());
                    nd++;
                end
            end
        end
        if (win >= 0) begin
            m_gv = 1'b1;
            m_gd = hd[win][15:0];
            void'(mq[win].pop_front());
            m_grant   = win;
            m_rr_down = (win + 1) % 5;
        end else if (gpu_out_ready) begin
            m_gv = 1'b0;
        end
        for (int s = 0; s < 4; s++) begin
            if (usel == s) begin
                m_sv[s]   = 1'b1;
                m_sd[s]   = hd[4][15:0];
                m_sdst[s] = hd[4][21:16];
            end else if (spine_out_ready[s]) begin
                m_sv[s] = 1'b0;
            end
        end
        if (usel >= 0) begin
            void'(mq[4].pop_front());
            m_rr_up = (usel + 1) % 4;
        end
        m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
        m_dir   = {usel >= 0, win >= 0};
        m_xfer  = (usel >= 0) || (win >= 0);
        for (int p = 0; p < 5; p++) if (acc[p]) mq[p].push_back(entry_of(p));
    endtask

    task automatic compare_all();
        logic [4:0] ef, ff;
        for (int p = 0; p < 5; p++) begin
            ef[p] = (mq[p].size() == 0);
            ff[p] = (mq[p].size() == 8);
        end
        check("rnd gpu_out_valid", gpu_out_valid, m_gv);
        check("rnd gpu_out_data", gpu_out_data, m_gd);
        check("rnd spine_out_valid", spine_out_valid, m_sv);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("rnd spine%0d data", s), spine_out_data[s*16 +: 16], m_sd[s]);
            check($sformatf("rnd spine%0d dest", s), spine_out_dest[s*6 +: 6], m_sdst[s]);
        end
        check("rnd drop_count", drop_count, m_drops);
        check("rnd current_grant", current_grant, m_grant);
        check("rnd routing_direction", routing_direction, m_dir);
        check("rnd busy", busy, m_xfer | m_gv | (|m_sv));
        check("rnd fifo_empty", fifo_empty, ef);
        check("rnd fifo_full", fifo_full, ff);
    endtask

    function automatic logic [5:0] rand_dest();
        logic [5:0] d;
        d = 6'($urandom);
        if ($urandom_range(1, 0) == 1) d[5:2] = GROUP;
        else if (d[5:2] == GROUP) d[5] = ~d[5];
        return d;
    endfunction

    task automatic rand_inputs();
        arb_enable    = ($urandom_range(7, 0) != 0);
        gpu_in_valid  = ($urandom_range(1, 0) == 1);
        gpu_in_dest   = rand_dest();
        gpu_in_data   = 16'($urandom);
        gpu_out_ready = ($urandom_range(3, 0) != 0);
        for (int s = 0; s < 4; s++) begin
            set_spine(s, ($urandom_range(2, 0) == 0), rand_dest(), 16'($urandom));
            spine_out_ready[s] = ($urandom_range(3, 0) != 0);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          port;
        logic [5:0]  dest;
        logic [15:0] data;
        logic        gv;
        logic [3:0]  sv;
        logic [2:0]  grant;
        logic [1:0]  dir;
        logic [7:0]  drops;
    } vec_t;

    vec_t tbl [8];
    int   acc_n, rx_n;
    logic ready_now, push_now, any_valid;

    initial begin
        tbl[0] = '{4, 6'b100001, 16'hA5A5, 1'b1, 4'b0000, 3'd4, 2'b01, 8'd0};
        tbl[1] = '{2, 6'b100011, 16'h1234, 1'b1, 4'b0000, 3'd2, 2'b01, 8'd0};
        tbl[2] = '{4, 6'b000101, 16'hBEEF, 1'b0, 4'b0001, 3'd2, 2'b10, 8'd0};
        tbl[3] = '{4, 6'b111110, 16'hCAFE, 1'b0, 4'b0010, 3'd2, 2'b10, 8'd0};
        tbl[4] = '{0, 6'b100000, 16'h0001, 1'b1, 4'b0000, 3'd0, 2'b01, 8'd0};
        tbl[5] = '{3, 6'b010000, 16'h7777, 1'b0, 4'b0000, 3'd0, 2'b00, 8'd1};
        tbl[6] = '{1, 6'b100010, 16'h0042, 1'b1, 4'b0000, 3'd1, 2'b01, 8'd1};
        tbl[7] = '{4, 6'b000000, 16'h0F0F, 1'b0, 4'b0100, 3'd1, 2'b10, 8'd1};

        idle_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        tick();
        check("reset gpu_out_valid", gpu_out_valid, 1'b0);
        check("reset spine_out_valid", spine_out_valid, 4'h0);
        check("reset gpu_in_ready", gpu_in_ready, 1'b1);
        check("reset spine_in_ready", spine_in_ready, 4'hF);
        check("reset fifo_empty", fifo_empty, 5'h1F);
        check("reset fifo_full", fifo_full, 5'h00);
        check("reset drop_count", drop_count, 8'd0);
        check("reset current_grant", current_grant, 3'd0);
        check("reset routing_direction", routing_direction, 2'b00);
        check("reset busy", busy, 1'b0);
        check("reset gpu_out_data", gpu_out_data, 16'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            push_one(tbl[i].port, tbl[i].dest, tbl[i].data);
            tick();
            check($sformatf("tbl%0d gpu_out_valid", i), gpu_out_valid, tbl[i].gv);
            if (tbl[i].gv) check($sformatf("tbl%0d gpu_out_data", i), gpu_out_data, tbl[i].data);
            check($sformatf("tbl%0d spine_out_valid", i), spine_out_valid, tbl[i].sv);
            for (int s = 0; s < 4; s++) begin
                if (tbl[i].sv[s]) begin
                    check($sformatf("tbl%0d spine%0d data", i, s),
                          spine_out_data[s*16 +: 16], tbl[i].data);
                    check($sformatf("tbl%0d spine%0d dest", i, s),
                          spine_out_dest[s*6 +: 6], tbl[i].dest);
                end
            end
            check($sformatf("tbl%0d current_grant", i), current_grant, tbl[i].grant);
            check($sformatf("tbl%0d routing_direction", i), routing_direction, tbl[i].dir);
            check($sformatf("tbl%0d drop_count", i), drop_count, tbl[i].drops);
            check($sformatf("tbl%0d busy", i), busy, tbl[i].gv | (|tbl[i].sv));
        end

        // Asynchronous reset in the middle of traffic.
        do_reset();
        gpu_out_ready   = 1'b0;
        spine_out_ready = 4'h0;
        set_spine(0, 1'b1, 6'b100000, 16'h1111);
        set_spine(3, 1'b1, 6'b000011, 16'h3333);
        gpu_in_valid = 1'b1;
        gpu_in_dest  = 6'b000001;
        gpu_in_data  = 16'h4444;
        tick();
        tick();
        tick();
        check("midreset pre gpu_out_valid", gpu_out_valid, 1'b1);
        check("midreset pre drop_count nonzero", drop_count != 8'd0, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("midreset gpu_out_valid", gpu_out_valid, 1'b0);
        check("midreset spine_out_valid", spine_out_valid, 4'h0);
        check("midreset spine_in_ready", spine_in_ready, 4'hF);
        check("midreset gpu_in_ready", gpu_in_ready, 1'b1);
        check("midreset drop_count", drop_count, 8'd0);
        check("midreset fifo_empty", fifo_empty, 5'h1F);
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();

        // Downlink round-robin fairness over repeated bursts.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 4; s++) set_spine(s, 1'b1, 6'b100000 | 6'(s), 16'(s + 1));
            tick();
            spine_in_valid = '0;
            for (int k = 0; k < 4; k++) begin
                tick();
                check($sformatf("rr b%0d k%0d valid", b, k), gpu_out_valid, 1'b1);
                check($sformatf("rr b%0d k%0d data", b, k), gpu_out_data, 16'(k + 1));
                check($sformatf("rr b%0d k%0d grant", b, k), current_grant, 3'(k));
            end
        end

        // Uplink balancing with all spines stalled, then a stalled fifth flit.
        do_reset();
        spine_out_ready = 4'h0;
        for (int i = 0; i < 5; i++) begin
            gpu_in_valid = 1'b1;
            gpu_in_dest  = 6'(8 + i);
            gpu_in_data  = 16'(16'h5000 + i);
            tick();
        end
        gpu_in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("up all spines valid", spine_out_valid, 4'hF);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("up spine%0d data", s), spine_out_data[s*16 +: 16], 16'(16'h5000 + s));
            check($sformatf("up spine%0d dest", s), spine_out_dest[s*6 +: 6], 6'(8 + s));
        end
        check("up fifth flit stalled", fifo_empty[4], 1'b0);
        check("up stalled direction", routing_direction, 2'b00);
        spine_out_ready = 4'b0001;
        tick();
        spine_out_ready = 4'h0;
        check("up fifth to spine0 data", spine_out_data[15:0], 16'h5004);
        check("up fifth to spine0 dest", spine_out_dest[5:0], 6'd12);
        check("up fifth valid", spine_out_valid, 4'hF);
        check("up fifth popped", fifo_empty[4], 1'b1);
        check("up fifth direction", routing_direction, 2'b10);

        // Full FIFO on spine 1 while the GPU sink is stalled.
        do_reset();
        gpu_out_ready = 1'b0;
        acc_n = 0;
        for (int c = 0; c < 15 && acc_n < 10; c++) begin
            set_spine(1, 1'b1, 6'b100001, 16'(100 + acc_n));
            ready_now = spine_in_ready[1];
            tick();
            if (ready_now) acc_n++;
        end
        check("full accepted count", acc_n, 9);
        check("full spine_in_ready1", spine_in_ready[1], 1'b0);
        check("full fifo_full1", fifo_full[1], 1'b1);
        gpu_out_ready = 1'b1;
        rx_n = 0;
        for (int c = 0; c < 40 && rx_n < 10; c++) begin
            if (gpu_out_valid) begin
                check($sformatf("full rx%0d", rx_n), gpu_out_data, 16'(100 + rx_n));
                rx_n++;
            end
            push_now = (acc_n < 10) && spine_in_ready[1];
            set_spine(1, push_now, 6'b100001, 16'(100 + acc_n));
            tick();
            if (push_now) acc_n++;
        end
        check("full received count", rx_n, 10);

        // Drop counting, freeze while disabled, saturation.
        do_reset();
        arb_enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            set_spine(2, 1'b1, 6'b001100, 16'(c));
            tick();
        end
        check("drop frozen count", drop_count, 8'd0);
        check("drop fifo_full2", fifo_full[2], 1'b1);
        check("drop spine_in_ready2", spine_in_ready[2], 1'b0);
        arb_enable = 1'b1;
        any_valid  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            set_spine(2, 1'b1, 6'b001100, 16'(c));
            tick();
            any_valid = any_valid | gpu_out_valid | (|spine_out_valid);
        end
        spine_in_valid = '0;
        tick();
        tick();
        check("drop saturated", drop_count, 8'd255);
        check("drop no output", any_valid, 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rand_inputs();
            check("rnd gpu_in_ready", gpu_in_ready, mq[4].size() < 8);
            for (int s = 0; s < 4; s++)
                check($sformatf("rnd spine_in_ready%0d", s), spine_in_ready[s], mq[s].size() < 8);
            model_step();
            tick();
            compare_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
